// File: rtl/odd_even_sort_if.sv
// Stream interface for odd_even_sort: job input handshake, result output
// handshake and the status signals. The sorter connects to the slave modport;
// the job producer / result consumer connects to the master modport.
interface odd_even_sort_if #(
  parameter int INPUTVALS      = 16,
  parameter int INPUTBITWIDTHS = 32
);
  localparam int POSW = $clog2(INPUTVALS);

  logic                                      in_valid;
  logic                                      in_ready;
  logic                                      descending;
  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  needs_sorting;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  sorted;
  logic [INPUTVALS-1:0][POSW-1:0]            sorted_positions;
  logic [POSW:0]                             phase_count;
  logic                                      error;

  modport slave (
    input  in_valid, descending, needs_sorting, out_ready,
    output in_ready, out_valid, sorted, sorted_positions, phase_count, error
  );

  modport master (
    output in_valid, descending, needs_sorting, out_ready,
    input  in_ready, out_valid, sorted, sorted_positions, phase_count, error
  );
endinterface

// File: rtl/odd_even_sort.sv
// Iterative odd-even transposition sorter. Accepts INPUTVALS unsigned keys per
// job, runs one full compare-exchange phase per clock and presents the keys
// in order together with their original indices. Equal keys never swap, so
// the result is stable.
// Optional feature macro: ODD_EVEN_SORT_EARLY_EXIT_EN -- when defined, the
// sort stops as soon as two consecutive phases perform no swap.
module odd_even_sort #(
  parameter int INPUTVALS      = 16,
  parameter int INPUTBITWIDTHS = 32
) (
  input  logic             clk,
  input  logic             reset,
  odd_even_sort_if.slave   bus
);
  localparam int POSW = $clog2(INPUTVALS);
  localparam logic [POSW:0] LAST_PHASE = (POSW+1)'(INPUTVALS-1);
  localparam logic [POSW:0] PHASE_ONE  = (POSW+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0] work_keys_reg;
  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0] step_keys;
  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0] sorted_reg;
  logic [INPUTVALS-1:0][POSW-1:0]           work_pos_reg;
  logic [INPUTVALS-1:0][POSW-1:0]           step_pos;
  logic [INPUTVALS-1:0][POSW-1:0]           sorted_pos_reg;
  logic [INPUTVALS-1:0][POSW-1:0]           init_pos;
  logic                                     desc_reg;
  logic [POSW:0]                            phase_reg;
  logic [POSW:0]                            phase_count_reg;
  logic                                     error_reg;

  // pair_swap[i] set: elements i and i+1 exchange in the current phase
  logic [INPUTVALS-2:0] pair_swap;
  logic                 accept;
  logic                 finish;
  logic                 final_phase;
  logic                 illegal;

  // Identity permutation used on load and as the reset value of the outputs
  genvar gi;
  generate
    for (gi = 0; gi < INPUTVALS; gi++) begin : g_init_pos
      assign init_pos[gi] = POSW'(gi);
    end
  endgenerate

  // Compare-exchange network: even phases pair (0,1),(2,3)..., odd phases
  // pair (1,2),(3,4)...; pairs within one phase are disjoint.
  generate
    for (gi = 0; gi < INPUTVALS - 1; gi++) begin : g_pair
      assign pair_swap[gi] = (phase_reg[0] == 1'(gi % 2)) &&
                             (desc_reg ? (work_keys_reg[gi] < work_keys_reg[gi+1])
                                       : (work_keys_reg[gi] > work_keys_reg[gi+1]));
    end

    for (gi = 0; gi < INPUTVALS; gi++) begin : g_elem
      if (gi == 0) begin : g_first
        assign step_keys[gi] = pair_swap[gi] ? work_keys_reg[gi+1] : work_keys_reg[gi];
        assign step_pos[gi]  = pair_swap[gi] ? work_pos_reg[gi+1]  : work_pos_reg[gi];
      end else if (gi == INPUTVALS - 1) begin : g_last
        assign step_keys[gi] = pair_swap[gi-1] ? work_keys_reg[gi-1] : work_keys_reg[gi];
        assign step_pos[gi]  = pair_swap[gi-1] ? work_pos_reg[gi-1]  : work_pos_reg[gi];
      end else begin : g_mid
        assign step_keys[gi] = pair_swap[gi]   ? work_keys_reg[gi+1] :
                               pair_swap[gi-1] ? work_keys_reg[gi-1] : work_keys_reg[gi];
        assign step_pos[gi]  = pair_swap[gi]   ? work_pos_reg[gi+1]  :
                               pair_swap[gi-1] ? work_pos_reg[gi-1]  : work_pos_reg[gi];
      end
    end
  endgenerate

`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
  logic any_swap;
  logic quiet_reg;  // previous phase of this job made no swap

  assign any_swap    = |pair_swap;
  assign final_phase = (phase_reg == LAST_PHASE) || (!any_swap && quiet_reg);

  // Remember whether the phase just executed was swap-free
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quiet_reg <= 1'b0;
    end else if (accept) begin
      quiet_reg <= 1'b0;
    end else if (state_reg == SORT) begin
      quiet_reg <= !any_swap;
    end
  end
`else
  assign final_phase = (phase_reg == LAST_PHASE);
`endif

  assign accept = (state_reg == IDLE) && bus.in_valid;
  assign finish = (state_reg == SORT) && final_phase;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic; an unknown encoding recovers to IDLE and flags error
  always_comb begin
    state_next = state_reg;
    illegal    = 1'b0;
    case (state_reg)
      IDLE: if (bus.in_valid)  state_next = SORT;
      SORT: if (final_phase)   state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: begin
        state_next = IDLE;
        illegal    = 1'b1;
      end
    endcase
  end

  // Working set, phase counter and registered result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_keys_reg   <= '0;
      work_pos_reg    <= init_pos;
      desc_reg        <= 1'b0;
      phase_reg       <= '0;
      sorted_reg      <= '0;
      sorted_pos_reg  <= init_pos;
      phase_count_reg <= '0;
      error_reg       <= 1'b0;
    end else begin
      error_reg <= illegal;

      if (accept) begin
        work_keys_reg <= bus.needs_sorting;
        work_pos_reg  <= init_pos;
        desc_reg      <= bus.descending;
        phase_reg     <= '0;
      end else if (state_reg == SORT) begin
        work_keys_reg <= step_keys;
        work_pos_reg  <= step_pos;
        phase_reg     <= phase_reg + PHASE_ONE;
      end

      if (finish) begin
        sorted_reg      <= step_keys;
        sorted_pos_reg  <= step_pos;
        phase_count_reg <= phase_reg + PHASE_ONE;
      end else if (illegal) begin
        sorted_reg      <= '0;
        sorted_pos_reg  <= init_pos;
        phase_count_reg <= '0;
      end
    end
  end

  assign bus.in_ready         = (state_reg == IDLE);
  assign bus.out_valid        = (state_reg == DONE);
  assign bus.sorted           = sorted_reg;
  assign bus.sorted_positions = sorted_pos_reg;
  assign bus.phase_count      = phase_count_reg;
  assign bus.error            = error_reg;

endmodule

// File: tb/tb_odd_even_sort.sv
// Testbench for odd_even_sort with 4 keys of 8 bits. A stable-sort reference
// model predicts each result; a negedge monitor compares the presented result
// whenever out_valid is high, and the driver checks handshake timing.
module tb_odd_even_sort;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  odd_even_sort_if #(.INPUTVALS(4), .INPUTBITWIDTHS(8)) bus ();

  odd_even_sort #(.INPUTVALS(4), .INPUTBITWIDTHS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int job_no   = 0;

  logic [3:0][7:0] exp_sorted = '0;
  logic [3:0][1:0] exp_pos    = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, want);
  endtask

  // Reference: stable insertion sort over (key, original index) pairs
  function automatic void model(input logic [3:0][7:0] k, input logic d,
                                output logic [3:0][7:0] s, output logic [3:0][1:0] p);
    int key[4];
    int idx[4];
    int t;
    for (int i = 0; i < 4; i++) begin
      key[i] = int'(k[i]);
      idx[i] = i;
    end
    for (int i = 1; i < 4; i++) begin
      for (int j = i; j > 0; j--) begin
        if (d ? (key[j-1] < key[j]) : (key[j-1] > key[j])) begin
          t = key[j]; key[j] = key[j-1]; key[j-1] = t;
          t = idx[j]; idx[j] = idx[j-1]; idx[j-1] = t;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      s[i] = 8'(key[i]);
      p[i] = 2'(idx[i]);
    end
  endfunction

  // Result monitor: every cycle a result is presented it must match the model
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.out_valid === 1'b1) begin
      chk("sorted", 32'(bus.sorted), 32'(exp_sorted));
      chk("positions", 32'(bus.sorted_positions), 32'(exp_pos));
      chk("error_in_done", 32'(bus.error), 32'd0);
`ifndef ODD_EVEN_SORT_EARLY_EXIT_EN
      chk("phase_count", 32'(bus.phase_count), 32'd4);
`endif
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_sorted"}, 32'(bus.sorted), 32'd0);
    chk({tag, "_positions"}, 32'(bus.sorted_positions), 32'h000000E4);
    chk({tag, "_phase_count"}, 32'(bus.phase_count), 32'd0);
    chk({tag, "_error"}, 32'(bus.error), 32'd0);
  endtask

  // Offer one job, measure latency, optionally hold off the result for
  // 'hold' cycles while offering new data, then release it.
  task automatic run_job(input logic [3:0][7:0] k, input logic d, input int hold,
                         input int want_lat);
    int guard;
    int lat;
    @(negedge clk);
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    model(k, d, exp_sorted, exp_pos);
    bus.needs_sorting = k;
    bus.descending    = d;
    bus.in_valid      = 1'b1;
    bus.out_ready     = (hold == 0);
    @(posedge clk);
    #1;
    chk("accept_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid      = (hold > 0);
    bus.needs_sorting = $urandom;
    bus.descending    = ~d;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.out_valid !== 1'b1) chk("out_valid_timeout", 32'd0, 32'd1);
`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
    chk("latency_cap", 32'(lat <= 4), 32'd1);
    chk("phase_count_vs_latency", 32'(bus.phase_count), 32'(lat));
`endif
    if (want_lat > 0) chk("latency", 32'(lat), 32'(want_lat));
    if (hold > 0) begin
      for (int c = 0; c < hold; c++) begin
        @(posedge clk);
        #1;
        bus.needs_sorting = $urandom;
        chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("release_out_valid", 32'(bus.out_valid), 32'd0);
      chk("release_in_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      chk("handoff_out_valid", 32'(bus.out_valid), 32'd0);
    end
    job_no++;
    $display("job %0d: keys=%h desc=%0d hold=%0d latency=%0d sorted=%h positions=%h phases=%0d",
             job_no, k, d, hold, lat, bus.sorted, bus.sorted_positions, bus.phase_count);
  endtask

  initial begin
    logic [3:0][7:0] ms;
    logic [3:0][1:0] mp;
    logic [3:0][7:0] rk;
    int full_lat;
    int pre_lat;
    bit  saw_valid;

`ifdef ODD_EVEN_SORT_EARLY_EXIT_EN
    full_lat = 0;
    pre_lat  = 2;
`else
    full_lat = 4;
    pre_lat  = 4;
`endif

    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
    bus.descending    = 1'b0;
    bus.needs_sorting = '0;

    // Pin the reference model with hand-computed results
    model(32'h01090305, 1'b0, ms, mp);
    chk("model_asc_keys", 32'(ms), 32'h09050301);
    chk("model_asc_pos", 32'(mp), 32'h87);
    model(32'h01090305, 1'b1, ms, mp);
    chk("model_desc_keys", 32'(ms), 32'h01030509);
    chk("model_desc_pos", 32'(mp), 32'hD2);
    model(32'h02070207, 1'b0, ms, mp);
    chk("model_stable_pos", 32'(mp), 32'h8D);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("por");

    // Directed jobs from the test plan
    run_job(32'h01090305, 1'b0, 0, 4);
    chk("dut_asc_keys", 32'(bus.sorted), 32'h09050301);
    chk("dut_asc_pos", 32'(bus.sorted_positions), 32'h87);

    // Reset pulse while idle clears the held result
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("idle_reset");
    @(negedge clk);
    reset = 1'b0;

    run_job(32'h01090305, 1'b1, 0, 4);
    chk("dut_desc_keys", 32'(bus.sorted), 32'h01030509);
    chk("dut_desc_pos", 32'(bus.sorted_positions), 32'hD2);
    run_job(32'h02070207, 1'b0, 0, 4);
    chk("dut_stable_pos", 32'(bus.sorted_positions), 32'h8D);

    // Backpressure with new data offered throughout
    run_job(32'h10FF0080, 1'b0, 10, 4);

    // Presorted input
    run_job(32'h04030201, 1'b0, 0, pre_lat);
    chk("presorted_phase_count", 32'(bus.phase_count), 32'(pre_lat));

    // Randomized jobs with small key range to force duplicates
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) rk[i] = 8'($urandom_range(0, 15));
      if (n % 5 == 0) rk = $urandom;
      run_job(rk, 1'($urandom_range(0, 1)), $urandom_range(0, 3), full_lat);
    end

    // Abort: reset two cycles into SORT, no result may appear
    @(negedge clk);
    bus.needs_sorting = 32'h04030201;
    bus.descending    = 1'b0;
    bus.in_valid      = 1'b1;
    bus.out_ready     = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_state("abort");
    @(negedge clk);
    reset = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) saw_valid = 1'b1;
    end
    chk("abort_no_result", 32'(saw_valid), 32'd0);
    check_reset_state("after_abort");
    $display("abort job: reset mid-sort, out_valid seen=%0d", saw_valid);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
